// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame counter slice.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FIELD_START  = 2'd0,
    FIELD_DATA   = 2'd1,
    FIELD_PARITY = 2'd2,
    FIELD_STOP   = 2'd3
  } field_e;

  localparam int MIN_PRESCALE = 4;
  localparam int MIN_DATA     = 5;

endpackage

// File: rtl/uart_rx_sample_decode.sv
// Combinational decode of the oversampling position into majority-vote
// sample strobes and the end-of-bit pulse.
module uart_rx_sample_decode #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  active,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale_q,
  output logic                  sample_stb,
  output logic                  sample_mid,
  output logic                  bit_done
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] half;

  assign half = prescale_q >> 1;

  // Three-sample window around the bit centre, the centre itself, and the last clock of the bit.
  always_comb begin
    sample_stb = 1'b0;
    sample_mid = 1'b0;
    bit_done   = 1'b0;
    if (active) begin
      sample_stb = (edge_cnt == half - ONE) || (edge_cnt == half) || (edge_cnt == half + ONE);
      sample_mid = (edge_cnt == half);
      bit_done   = (edge_cnt == prescale_q - ONE);
    end
  end

endmodule

// File: rtl/uart_rx_frame_counter.sv
// UART RX edge/bit counter: tracks the oversampling clock within a bit and
// the bit within a frame, with runtime frame configuration latched per frame.
module uart_rx_frame_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int MAX_DATA   = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  par_en,
  input  logic                  stop2,
  input  logic [3:0]            data_len,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic [1:0]            field,
  output logic                  sample_stb,
  output logic                  sample_mid,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam logic [PRESCALE_W-1:0] ONE_E       = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] MIN_PRE_L   = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [3:0]            MIN_DATA_L  = 4'(MIN_DATA);
  localparam logic [3:0]            MAX_DATA_L  = 4'(MAX_DATA);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic [3:0]            data_len_q, data_len_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;

  logic                  running;
  logic                  cfg_ok;
  logic                  load_cfg;
  logic [3:0]            frame_len;
  logic [3:0]            last_bit;
  field_e                field_dec;

  assign running   = (state_q == ST_RUN);
  assign cfg_ok    = (prescale >= MIN_PRE_L) && (data_len >= MIN_DATA_L) && (data_len <= MAX_DATA_L);
  assign frame_len = 4'd2 + data_len_q + {3'b000, par_en_q} + {3'b000, stop2_q};
  assign last_bit  = frame_len - 4'd1;

  uart_rx_sample_decode #(
    .PRESCALE_W(PRESCALE_W)
  ) u_decode (
    .active     (running),
    .edge_cnt   (edge_cnt_q),
    .prescale_q (prescale_q),
    .sample_stb (sample_stb),
    .sample_mid (sample_mid),
    .bit_done   (bit_done)
  );

  assign frame_done = bit_done && (bit_cnt_q == last_bit);

  // Field tag follows the latched frame layout: start, data bits, optional parity, then stop bits.
  always_comb begin
    field_dec = FIELD_START;
    if (running) begin
      if (bit_cnt_q == 4'd0) begin
        field_dec = FIELD_START;
      end else if (bit_cnt_q <= data_len_q) begin
        field_dec = FIELD_DATA;
      end else if (par_en_q && (bit_cnt_q == data_len_q + 4'd1)) begin
        field_dec = FIELD_PARITY;
      end else begin
        field_dec = FIELD_STOP;
      end
    end
  end

  // Next-state logic: dropping enable wins over everything; config is only sampled at a frame start.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    cfg_err_d  = cfg_err_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    data_len_d = data_len_q;
    prescale_d = prescale_q;
    load_cfg   = 1'b0;

    if (!enable) begin
      state_d    = ST_IDLE;
      edge_cnt_d = '0;
      bit_cnt_d  = 4'd0;
      cfg_err_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          load_cfg = 1'b1;
        end
        ST_RUN: begin
          if (bit_done) begin
            edge_cnt_d = '0;
            if (frame_done) begin
              bit_cnt_d = 4'd0;
              load_cfg  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            edge_cnt_d = edge_cnt_q + ONE_E;
          end
        end
        ST_HOLD: begin
          edge_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          cfg_err_d  = 1'b1;
        end
        default: begin
          state_d    = ST_IDLE;
          edge_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          cfg_err_d  = 1'b0;
        end
      endcase

      if (load_cfg) begin
        par_en_d   = par_en;
        stop2_d    = stop2;
        data_len_d = data_len;
        prescale_d = prescale;
        bit_cnt_d  = 4'd0;
        if (!cfg_ok) begin
          state_d    = ST_HOLD;
          edge_cnt_d = '0;
          cfg_err_d  = 1'b1;
        end else begin
          state_d    = ST_RUN;
          edge_cnt_d = (state_q == ST_IDLE) ? ONE_E : '0;
          cfg_err_d  = 1'b0;
        end
      end
    end
  end

  // State, counters and latched configuration registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      cfg_err_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      data_len_q <= 4'd0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      cfg_err_q  <= cfg_err_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      data_len_q <= data_len_d;
      prescale_q <= prescale_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  assign field    = field_dec;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Directed testbench for uart_rx_frame_counter with hand-computed expectations.
module tb_uart_rx_frame_counter;

  localparam int F_START  = 0;
  localparam int F_DATA   = 1;
  localparam int F_PARITY = 2;
  localparam int F_STOP   = 3;

  logic       CLK;
  logic       RST;
  logic       enable;
  logic       par_en;
  logic       stop2;
  logic [3:0] data_len;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] field;
  logic       sample_stb;
  logic       sample_mid;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  uart_rx_frame_counter dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .par_en     (par_en),
    .stop2      (stop2),
    .data_len   (data_len),
    .prescale   (prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .field      (field),
    .sample_stb (sample_stb),
    .sample_mid (sample_mid),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  // 10 ns free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input int pre, input int dlen,
                               input logic par, input logic s2);
    prescale = 6'(pre);
    data_len = 4'(dlen);
    par_en   = par;
    stop2    = s2;
    enable   = en;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_edge", int'(edge_cnt), 0);
    checkOutput("rst_bit", int'(bit_cnt), 0);
    checkOutput("rst_cfg_err", int'(cfg_err), 0);
    checkOutput("rst_stb", int'(sample_stb), 0);
    RST = 1'b0;
    tick();
    checkOutput("idle_edge", int'(edge_cnt), 0);
    checkOutput("idle_field", int'(field), F_START);

    $display("[TB] frame 8N1, prescale 8, data_len change mid-frame");
    applyStimulus(1'b1, 8, 8, 1'b0, 1'b0);
    for (int cyc = 0; cyc <= 136; cyc++) begin
      if (cyc == 0) begin
        checkOutput("t1_c0_edge", int'(edge_cnt), 0);
        checkOutput("t1_c0_bit", int'(bit_cnt), 0);
      end
      if (cyc == 1) checkOutput("t1_c1_edge", int'(edge_cnt), 1);
      if (cyc == 2) checkOutput("t1_stb_e2", int'(sample_stb), 0);
      if (cyc == 3) checkOutput("t1_stb_e3", int'(sample_stb), 1);
      if (cyc == 3) checkOutput("t1_mid_e3", int'(sample_mid), 0);
      if (cyc == 4) checkOutput("t1_stb_e4", int'(sample_stb), 1);
      if (cyc == 4) checkOutput("t1_mid_e4", int'(sample_mid), 1);
      if (cyc == 5) checkOutput("t1_stb_e5", int'(sample_stb), 1);
      if (cyc == 6) checkOutput("t1_stb_e6", int'(sample_stb), 0);
      if (cyc == 6) checkOutput("t1_done_e6", int'(bit_done), 0);
      if (cyc == 7) checkOutput("t1_done_e7", int'(bit_done), 1);
      if (cyc == 8) begin
        checkOutput("t1_c8_bit", int'(bit_cnt), 1);
        checkOutput("t1_c8_edge", int'(edge_cnt), 0);
        checkOutput("t1_c8_field", int'(field), F_DATA);
      end
      if (cyc == 20) data_len = 4'd5;
      if (cyc == 48) checkOutput("t1_bit6_field", int'(field), F_DATA);
      if (cyc == 72) begin
        checkOutput("t1_bit9", int'(bit_cnt), 9);
        checkOutput("t1_bit9_field", int'(field), F_STOP);
      end
      if (cyc == 78) checkOutput("t1_fd_78", int'(frame_done), 0);
      if (cyc == 79) begin
        checkOutput("t1_fd_79", int'(frame_done), 1);
        checkOutput("t1_79_bit", int'(bit_cnt), 9);
        checkOutput("t1_79_edge", int'(edge_cnt), 7);
      end
      if (cyc == 80) begin
        checkOutput("t1_80_bit", int'(bit_cnt), 0);
        checkOutput("t1_80_edge", int'(edge_cnt), 0);
        checkOutput("t1_80_fd", int'(frame_done), 0);
        checkOutput("t1_80_field", int'(field), F_START);
      end
      if (cyc == 88)  checkOutput("t3_88_field", int'(field), F_DATA);
      if (cyc == 120) checkOutput("t3_120_field", int'(field), F_DATA);
      if (cyc == 128) checkOutput("t3_128_field", int'(field), F_STOP);
      if (cyc == 134) checkOutput("t3_fd_134", int'(frame_done), 0);
      if (cyc == 135) begin
        checkOutput("t3_fd_135", int'(frame_done), 1);
        checkOutput("t3_135_bit", int'(bit_cnt), 6);
        checkOutput("t3_135_edge", int'(edge_cnt), 7);
      end
      if (cyc == 136) begin
        checkOutput("t3_136_bit", int'(bit_cnt), 0);
        checkOutput("t3_136_edge", int'(edge_cnt), 0);
      end
      if (cyc != 136) tick();
    end
    enable = 1'b0;
    tick();
    checkOutput("t3_off_edge", int'(edge_cnt), 0);

    $display("[TB] frame 7E2, prescale 16");
    applyStimulus(1'b1, 16, 7, 1'b1, 1'b1);
    for (int cyc = 0; cyc <= 175; cyc++) begin
      if (cyc == 6)   checkOutput("t2_stb_e6", int'(sample_stb), 0);
      if (cyc == 7)   checkOutput("t2_stb_e7", int'(sample_stb), 1);
      if (cyc == 8)   checkOutput("t2_mid_e8", int'(sample_mid), 1);
      if (cyc == 9)   checkOutput("t2_stb_e9", int'(sample_stb), 1);
      if (cyc == 10)  checkOutput("t2_stb_e10", int'(sample_stb), 0);
      if (cyc == 15)  checkOutput("t2_done_e15", int'(bit_done), 1);
      if (cyc == 112) checkOutput("t2_bit7_field", int'(field), F_DATA);
      if (cyc == 128) begin
        checkOutput("t2_bit8", int'(bit_cnt), 8);
        checkOutput("t2_bit8_field", int'(field), F_PARITY);
      end
      if (cyc == 144) checkOutput("t2_bit9_field", int'(field), F_STOP);
      if (cyc == 160) checkOutput("t2_bit10_field", int'(field), F_STOP);
      if (cyc == 174) checkOutput("t2_fd_174", int'(frame_done), 0);
      if (cyc == 175) checkOutput("t2_fd_175", int'(frame_done), 1);
      if (cyc != 175) tick();
    end
    enable = 1'b0;
    #1;
    checkOutput("t2_fd_with_off", int'(frame_done), 1);
    tick();
    checkOutput("t2_off_edge", int'(edge_cnt), 0);
    checkOutput("t2_off_bit", int'(bit_cnt), 0);
    checkOutput("t2_off_fd", int'(frame_done), 0);
    checkOutput("t2_off_field", int'(field), F_START);

    $display("[TB] abort mid-frame");
    applyStimulus(1'b1, 8, 8, 1'b0, 1'b0);
    repeat (35) tick();
    checkOutput("t4_bit", int'(bit_cnt), 4);
    checkOutput("t4_edge", int'(edge_cnt), 3);
    enable = 1'b0;
    tick();
    checkOutput("t4_ab_edge", int'(edge_cnt), 0);
    checkOutput("t4_ab_bit", int'(bit_cnt), 0);
    checkOutput("t4_ab_fd", int'(frame_done), 0);
    checkOutput("t4_ab_stb", int'(sample_stb), 0);
    repeat (3) tick();
    checkOutput("t4_idle_edge", int'(edge_cnt), 0);
    enable = 1'b1;
    checkOutput("t4_re_c0_edge", int'(edge_cnt), 0);
    tick();
    checkOutput("t4_re_c1_edge", int'(edge_cnt), 1);
    checkOutput("t4_re_c1_bit", int'(bit_cnt), 0);

    $display("[TB] illegal configurations");
    enable = 1'b0;
    tick();
    applyStimulus(1'b1, 3, 8, 1'b0, 1'b0);
    checkOutput("t5_pre3_c0_err", int'(cfg_err), 0);
    tick();
    checkOutput("t5_pre3_err", int'(cfg_err), 1);
    checkOutput("t5_pre3_edge", int'(edge_cnt), 0);
    checkOutput("t5_pre3_bit", int'(bit_cnt), 0);
    checkOutput("t5_pre3_stb", int'(sample_stb), 0);
    checkOutput("t5_pre3_done", int'(bit_done), 0);
    repeat (3) tick();
    checkOutput("t5_hold_err", int'(cfg_err), 1);
    checkOutput("t5_hold_edge", int'(edge_cnt), 0);
    enable = 1'b0;
    tick();
    checkOutput("t5_clear_err", int'(cfg_err), 0);
    applyStimulus(1'b1, 8, 4, 1'b0, 1'b0);
    tick();
    checkOutput("t5_dl4_err", int'(cfg_err), 1);
    enable = 1'b0;
    tick();
    applyStimulus(1'b1, 8, 10, 1'b0, 1'b0);
    tick();
    checkOutput("t5_dl10_err", int'(cfg_err), 1);
    enable = 1'b0;
    tick();
    applyStimulus(1'b1, 4, 9, 1'b0, 1'b0);
    tick();
    checkOutput("t5_dl9_err", int'(cfg_err), 0);
    checkOutput("t5_dl9_edge", int'(edge_cnt), 1);

    $display("[TB] reset mid-frame");
    enable = 1'b0;
    tick();
    applyStimulus(1'b1, 8, 8, 1'b0, 1'b0);
    repeat (20) tick();
    checkOutput("t6_pre_mid", int'(sample_mid), 1);
    checkOutput("t6_pre_bit", int'(bit_cnt), 2);
    RST = 1'b1;
    prescale = 6'd4;
    tick();
    checkOutput("t6_rst_edge", int'(edge_cnt), 0);
    checkOutput("t6_rst_bit", int'(bit_cnt), 0);
    checkOutput("t6_rst_stb", int'(sample_stb), 0);
    checkOutput("t6_rst_mid", int'(sample_mid), 0);
    checkOutput("t6_rst_field", int'(field), F_START);
    checkOutput("t6_rst_err", int'(cfg_err), 0);
    RST = 1'b0;
    repeat (3) tick();
    checkOutput("t6_c3_edge", int'(edge_cnt), 3);
    checkOutput("t6_c3_done", int'(bit_done), 1);
    checkOutput("t6_c3_stb", int'(sample_stb), 1);
    tick();
    checkOutput("t6_c4_bit", int'(bit_cnt), 1);
    checkOutput("t6_c4_edge", int'(edge_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
